// File: rtl/fetch_align_unit.sv
// Fetch/align stage: pulls one instruction byte per cycle at the current PC,
// assembles 1- or 2-byte instructions (opcode + optional immediate) and hands
// them to the decoder over a valid/ready handshake. Also drives the
// sequential PC-advance request back to the program counter.
module fetch_align_unit #(
  parameter logic [3:0] TWO_BYTE_OP = 4'hC,
  parameter logic [7:0] NOP_BYTE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr_in,
  input  logic [7:0] pc_cur,
  input  logic       stall,
  input  logic       flush,
  input  logic       out_ready,
  output logic       pc_adv,
  output logic       out_valid,
  output logic [7:0] out_instr,
  output logic [7:0] out_imm,
  output logic       out_two_byte,
  output logic [7:0] out_pc,
  output logic [7:0] out_pc_next
);

  typedef enum logic {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_op_reg;
  logic [7:0] r_op_pc;
  logic       r_out_valid;
  logic [7:0] r_out_instr;
  logic [7:0] r_out_imm;
  logic       r_out_two_byte;
  logic [7:0] r_out_pc;
  logic [7:0] r_out_pc_next;

  logic       w_free;
  logic       w_accept;
  logic       w_is_two_byte;

  // Output slot is free when empty or being drained; a byte is taken only
  // when nothing (stall, flush, reset) blocks the pipeline.
  always_comb begin
    w_free        = !r_out_valid || out_ready;
    w_accept      = w_free && !stall && !flush && !rst;
    w_is_two_byte = (instr_in[7:4] == TWO_BYTE_OP);
  end

  assign pc_adv       = w_accept;
  assign out_valid    = r_out_valid;
  assign out_instr    = r_out_instr;
  assign out_imm      = r_out_imm;
  assign out_two_byte = r_out_two_byte;
  assign out_pc       = r_out_pc;
  assign out_pc_next  = r_out_pc_next;

  // Assembly FSM with registered outputs; flush outranks stall and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FETCH_OP;
      r_op_reg       <= NOP_BYTE;
      r_op_pc        <= '0;
      r_out_valid    <= 1'b0;
      r_out_instr    <= NOP_BYTE;
      r_out_imm      <= NOP_BYTE;
      r_out_two_byte <= 1'b0;
      r_out_pc       <= '0;
      r_out_pc_next  <= '0;
    end else if (flush) begin
      r_state        <= FETCH_OP;
      r_op_reg       <= NOP_BYTE;
      r_out_valid    <= 1'b0;
      r_out_instr    <= NOP_BYTE;
      r_out_imm      <= NOP_BYTE;
      r_out_two_byte <= 1'b0;
      r_out_pc       <= NOP_BYTE;
      r_out_pc_next  <= NOP_BYTE;
    end else if (w_accept) begin
      unique case (r_state)
        FETCH_OP: begin
          r_op_reg <= instr_in;
          r_op_pc  <= pc_cur;
          if (w_is_two_byte) begin
            r_state     <= FETCH_IMM;
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid    <= 1'b1;
            r_out_instr    <= instr_in;
            r_out_imm      <= NOP_BYTE;
            r_out_two_byte <= 1'b0;
            r_out_pc       <= pc_cur;
            r_out_pc_next  <= pc_cur + 8'd1;
          end
        end
        FETCH_IMM: begin
          r_state        <= FETCH_OP;
          r_out_valid    <= 1'b1;
          r_out_instr    <= r_op_reg;
          r_out_imm      <= instr_in;
          r_out_two_byte <= 1'b1;
          r_out_pc       <= r_op_pc;
          r_out_pc_next  <= r_op_pc + 8'd2;
        end
        default: r_state <= FETCH_OP;
      endcase
    end else if (r_out_valid && out_ready) begin
      // Handshake still drains the output slot while stalled.
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_align_unit.sv
// Bench for fetch_align_unit: acts as instruction memory and program counter,
// keeps a queue-based model of the instruction stream parsed straight from
// memory, and adds hand-computed literal checks for the directed scenarios.
module tb_fetch_align_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_cur = 8'h00;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] flush_pc = 8'h00;
  logic [7:0] instr_in;
  logic       pc_adv;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [7:0] out_imm;
  logic       out_two_byte;
  logic [7:0] out_pc;
  logic [7:0] out_pc_next;

  logic [7:0] mem [256];
  assign instr_in = mem[pc_cur];

  int n_pass  = 0;
  int n_total = 0;

  fetch_align_unit #(.TWO_BYTE_OP(4'hC), .NOP_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_cur(pc_cur),
    .stall(stall), .flush(flush), .out_ready(out_ready), .pc_adv(pc_adv),
    .out_valid(out_valid), .out_instr(out_instr), .out_imm(out_imm),
    .out_two_byte(out_two_byte), .out_pc(out_pc), .out_pc_next(out_pc_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model: instruction stream from memory ----
  typedef struct {
    logic [7:0] ins;
    logic [7:0] imm;
    logic [7:0] pc;
    logic [7:0] pcn;
    logic       two;
  } exp_t;

  exp_t       q[$];
  logic [7:0] parse_addr = 8'h00;
  logic       need_sync  = 1'b1;
  logic       prev_flush = 1'b0;
  logic       prev_hold  = 1'b0;
  logic       prev_rst   = 1'b1;

  task automatic gen(output exp_t e);
    logic [7:0] op;
    op    = mem[parse_addr];
    e.ins = op;
    e.pc  = parse_addr;
    if (op[7:4] == 4'hC) begin
      e.imm = mem[8'(parse_addr + 8'd1)];
      e.two = 1'b1;
      e.pcn = parse_addr + 8'd2;
    end else begin
      e.imm = 8'h00;
      e.two = 1'b0;
      e.pcn = parse_addr + 8'd1;
    end
    parse_addr = e.pcn;
  endtask

  // Compare process: checks DUT against the stream model every cycle.
  always @(negedge clk) begin
    exp_t e;
    logic exp_adv;
    exp_adv = !rst && !flush && !stall && (!out_valid || out_ready);
    if (rst) begin
      chk("rst_pc_adv", pc_adv, 0);
      if (prev_rst) begin
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
      end
      q.delete();
      need_sync  = 1'b1;
      prev_flush = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (need_sync) begin
        parse_addr = pc_cur;
        need_sync  = 1'b0;
      end
      chk("m_pc_adv", pc_adv, exp_adv);
      if (prev_flush) begin
        chk("m_flush_valid", out_valid, 0);
        chk("m_flush_instr", out_instr, 0);
        chk("m_flush_imm", out_imm, 0);
      end
      if (prev_hold) chk("m_hold_valid", out_valid, 1);
      if (flush) begin
        q.delete();
        parse_addr = flush_pc;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          gen(e);
          q.push_back(e);
        end
        chk("m_instr", out_instr, q[0].ins);
        chk("m_imm", out_imm, q[0].imm);
        chk("m_pc", out_pc, q[0].pc);
        chk("m_pc_next", out_pc_next, q[0].pcn);
        chk("m_two", out_two_byte, q[0].two);
        if (out_ready) void'(q.pop_front());
      end
      prev_flush = flush;
      prev_hold  = out_valid && !out_ready && !flush;
    end
    prev_rst = rst;
  end

  // ---------------- stimulus -------------------------------------------
  task automatic cyc();
    logic adv_s;
    @(negedge clk);
    adv_s = pc_adv;
    @(posedge clk);
    #1;
    if (flush) pc_cur = flush_pc;
    else if (adv_s) pc_cur = pc_cur + 8'd1;
  endtask

  task automatic chk_out(input string n, input logic [7:0] ins, input logic [7:0] imm,
                         input logic [7:0] pc, input logic [7:0] pcn, input logic two);
    chk({n, "_valid"}, out_valid, 1);
    chk({n, "_instr"}, out_instr, ins);
    chk({n, "_imm"}, out_imm, imm);
    chk({n, "_pc"}, out_pc, pc);
    chk({n, "_pcn"}, out_pc_next, pcn);
    chk({n, "_two"}, out_two_byte, two);
  endtask

  initial begin
    logic [15:0] ready_pat;
    logic [15:0] stall_pat;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'h01;
    mem[0] = 8'h00; mem[1] = 8'h05; mem[2] = 8'h29; mem[3] = 8'h11;
    mem[4] = 8'hC0; mem[5] = 8'h42; mem[6] = 8'h07; mem[7] = 8'hC3;
    mem[8] = 8'h66; mem[8'h10] = 8'h21; mem[8'hFF] = 8'hC7;
    mem[8'h30] = 8'hC5; mem[8'h31] = 8'h77; mem[8'h40] = 8'h12;
    mem[8'h50] = 8'h13; mem[8'h51] = 8'hC4; mem[8'h52] = 8'h99;
    mem[8'h53] = 8'h22; mem[8'h54] = 8'hC1; mem[8'h55] = 8'h0A;
    mem[8'h56] = 8'h5C; mem[8'h57] = 8'hCF; mem[8'h58] = 8'hFE;
    mem[8'h59] = 8'h31; mem[8'h5A] = 8'hC2; mem[8'h5B] = 8'h80;

    // Reset for two cycles
    cyc(); cyc();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_instr", out_instr, 8'h00);
    chk("rst2_pc_adv", pc_adv, 0);
    rst = 1'b0;
    #1;
    chk("rel_pc_adv", pc_adv, 1);
    chk("rel_pc", pc_cur, 8'h00);

    // Back-to-back 1-byte instructions
    cyc(); chk_out("s0", 8'h00, 8'h00, 8'h00, 8'h01, 1'b0);
    cyc(); chk_out("s1", 8'h05, 8'h00, 8'h01, 8'h02, 1'b0);
    cyc(); chk_out("s2", 8'h29, 8'h00, 8'h02, 8'h03, 1'b0);
    cyc(); chk_out("s3", 8'h11, 8'h00, 8'h03, 8'h04, 1'b0);

    // Two-byte instruction with one-cycle bubble
    cyc();
    chk("tb_bubble", out_valid, 0);
    chk("tb_pc5", pc_cur, 8'h05);
    cyc();
    chk_out("tb", 8'hC0, 8'h42, 8'h04, 8'h06, 1'b1);
    chk("tb_pc6", pc_cur, 8'h06);

    // Backpressure: out_ready low holds everything
    out_ready = 1'b0;
    #1;
    chk("bp_pc_adv", pc_adv, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("bp_hold", 8'hC0, 8'h42, 8'h04, 8'h06, 1'b1);
      chk("bp_pc", pc_cur, 8'h06);
    end
    out_ready = 1'b1;
    cyc(); chk_out("bp_rel", 8'h07, 8'h00, 8'h06, 8'h07, 1'b0);

    // Stall with backpressure, then handshake completing under stall
    stall = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("st_hold", 8'h07, 8'h00, 8'h06, 8'h07, 1'b0);
      chk("st_pc", pc_cur, 8'h07);
    end
    out_ready = 1'b1;
    #1;
    chk("st_pc_adv", pc_adv, 0);
    cyc();
    chk("st_drain_valid", out_valid, 0);
    chk("st_drain_pc", pc_cur, 8'h07);
    stall = 1'b0;
    cyc();
    chk("c3_bubble", out_valid, 0);
    chk("c3_pc", pc_cur, 8'h08);

    // Flush while waiting for the immediate of C3
    flush = 1'b1; flush_pc = 8'h10;
    #1;
    chk("fl_pc_adv", pc_adv, 0);
    cyc();
    chk("fl_valid", out_valid, 0);
    flush = 1'b0;
    cyc(); chk_out("fl_next", 8'h21, 8'h00, 8'h10, 8'h11, 1'b0);

    // Flush together with out_ready: flush wins, no PC advance
    flush = 1'b1; flush_pc = 8'h20;
    #1;
    chk("flr_pc_adv", pc_adv, 0);
    cyc();
    chk("flr_valid", out_valid, 0);
    chk("flr_instr", out_instr, 8'h00);

    // PC wrap across 0xFF -> 0x00
    mem[0] = 8'h3A;
    flush_pc = 8'hFF;
    cyc();
    flush = 1'b0;
    cyc();
    chk("wr_bubble", out_valid, 0);
    chk("wr_pc0", pc_cur, 8'h00);
    cyc(); chk_out("wr", 8'hC7, 8'h3A, 8'hFF, 8'h01, 1'b1);

    // Reset while half an instruction is assembled
    flush = 1'b1; flush_pc = 8'h30;
    cyc();
    flush = 1'b0;
    cyc();
    chk("ri_bubble", out_valid, 0);
    rst = 1'b1;
    cyc();
    chk("ri_valid", out_valid, 0);
    rst = 1'b0; pc_cur = 8'h40;
    cyc(); chk_out("ri_next", 8'h12, 8'h00, 8'h40, 8'h41, 1'b0);

    // Mixed stream under irregular ready/stall, checked by the model
    flush = 1'b1; flush_pc = 8'h50;
    cyc();
    flush = 1'b0;
    ready_pat = 16'b1011_0110_1110_0101;
    stall_pat = 16'b0000_1000_0100_0000;
    for (int i = 0; i < 24; i++) begin
      out_ready = ready_pat[i % 16];
      stall     = stall_pat[i % 16];
      cyc();
    end
    out_ready = 1'b1; stall = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
